// File: rtl/leak_pwr_input_filter_pkg.sv
// Shared definitions for the leak / RMC-enable input conditioning stage.
package leak_pwr_input_filter_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        GRANT    = 2'd2,
        WAIT_REL = 2'd3
    } clrState_t;

    // Bit positions within the sticky history vector
    localparam int unsigned LARGE = 0;
    localparam int unsigned SMALL = 1;
    localparam int unsigned RMC   = 2;

    localparam int unsigned DEF_DEB_ASSERT_MS  = 20;
    localparam int unsigned DEF_DEB_RELEASE_MS = 150;
    localparam int unsigned DEF_CLR_HOLD_MS    = 10;
    localparam int unsigned DEF_CNT_W          = 16;

endpackage

// File: rtl/leak_pwr_input_filter_debounce.sv
// One debounce channel: 2-FF synchroniser plus ms-tick qualification counter
// with separate thresholds for moving to and away from the fault level.
module sig_debounce #(
    parameter int unsigned CNT_W     = 16,
    parameter logic        RESET_VAL = 1'b1,
    parameter logic        FAULT_VAL = 1'b0
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iTick,
    input  logic             iAsync,
    input  logic [CNT_W-1:0] iAssertTh,
    input  logic [CNT_W-1:0] iReleaseTh,
    output logic             oFilt
);

    logic [1:0]       syncFf;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] thresh;
    logic [CNT_W:0]   countInc;

    always_comb begin
        thresh   = (syncFf[1] == FAULT_VAL) ? iAssertTh : iReleaseTh;
        countInc = {1'b0, count} + {{CNT_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            syncFf <= {2{RESET_VAL}};
            count  <= '0;
            oFilt  <= RESET_VAL;
        end else begin
            syncFf <= {syncFf[0], iAsync};
            // Any cycle where the input agrees with the output restarts qualification
            if (syncFf[1] == oFilt) begin
                count <= '0;
            end else if (iTick) begin
                if (countInc >= {1'b0, thresh}) begin
                    oFilt <= syncFf[1];
                    count <= '0;
                end else if (count != '1) begin
                    count <= countInc[CNT_W-1:0];
                end
            end
        end
    end

endmodule

// File: rtl/leak_pwr_input_filter.sv
// Conditions raw leak / RMC-enable inputs for the master power sequencer and
// runs the BMC latch-clear handshake.
module leak_pwr_input_filter
    import leak_pwr_input_filter_pkg::*;
#(
    parameter int unsigned DEB_ASSERT_MS  = DEF_DEB_ASSERT_MS,
    parameter int unsigned DEB_RELEASE_MS = DEF_DEB_RELEASE_MS,
    parameter int unsigned CLR_HOLD_MS    = DEF_CLR_HOLD_MS,
    parameter int unsigned CNT_W          = DEF_CNT_W
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick_1ms,
    input  logic       iLarge_Leak_Raw_N,
    input  logic       iSmall_Leak_Raw_N,
    input  logic       iRMC_PWR_Enable_Raw,
    input  logic       iBMC_Clear_Req,
    output logic       oLarge_Leak_Detect_N,
    output logic       oSmall_Leak_Detect_N,
    output logic       oRMC_PWR_Enable,
    output logic       oLatch_Clear,
    output logic       oClear_Reject,
    output logic [2:0] oLeak_Sticky,
    output logic [1:0] oDBG_FILT_FSM
);

    localparam logic [CNT_W-1:0] ASSERT_TH  = CNT_W'(DEB_ASSERT_MS);
    localparam logic [CNT_W-1:0] RELEASE_TH = CNT_W'(DEB_RELEASE_MS);
    localparam logic [CNT_W-1:0] HOLD_TH    = CNT_W'(CLR_HOLD_MS);

    logic filtLarge, filtSmall, filtEn;
    logic filtLargeQ, filtSmallQ, filtEnQ;
    logic [1:0] reqSync;
    clrState_t state;
    logic [CNT_W-1:0] holdCnt;
    logic [CNT_W:0] holdInc;
    logic [2:0] setEv;
    logic grantOk, clearNow, rejectNow;

    sig_debounce #(.CNT_W(CNT_W), .RESET_VAL(1'b1), .FAULT_VAL(1'b0)) uLargeDeb (
        .iClk(iClk), .iRst(iRst), .iTick(iTick_1ms), .iAsync(iLarge_Leak_Raw_N),
        .iAssertTh(ASSERT_TH), .iReleaseTh(RELEASE_TH), .oFilt(filtLarge)
    );

    sig_debounce #(.CNT_W(CNT_W), .RESET_VAL(1'b1), .FAULT_VAL(1'b0)) uSmallDeb (
        .iClk(iClk), .iRst(iRst), .iTick(iTick_1ms), .iAsync(iSmall_Leak_Raw_N),
        .iAssertTh(ASSERT_TH), .iReleaseTh(RELEASE_TH), .oFilt(filtSmall)
    );

    sig_debounce #(.CNT_W(CNT_W), .RESET_VAL(1'b0), .FAULT_VAL(1'b0)) uEnableDeb (
        .iClk(iClk), .iRst(iRst), .iTick(iTick_1ms), .iAsync(iRMC_PWR_Enable_Raw),
        .iAssertTh(ASSERT_TH), .iReleaseTh(RELEASE_TH), .oFilt(filtEn)
    );

    assign oLarge_Leak_Detect_N = filtLarge;
    assign oSmall_Leak_Detect_N = filtSmall;
    assign oDBG_FILT_FSM        = state;

    always_comb begin
        setEv[LARGE] = filtLargeQ & ~filtLarge;
        setEv[SMALL] = filtSmallQ & ~filtSmall;
        setEv[RMC]   = filtEnQ & ~filtEn;
        grantOk      = filtEn & filtLarge & filtSmall;
        clearNow     = (state == GRANT) & grantOk;
        rejectNow    = (state == GRANT) & ~grantOk;
        holdInc      = {1'b0, holdCnt} + {{CNT_W{1'b0}}, 1'b1};
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            filtLargeQ      <= 1'b1;
            filtSmallQ      <= 1'b1;
            filtEnQ         <= 1'b0;
            reqSync         <= '0;
            state           <= IDLE;
            holdCnt         <= '0;
            oLatch_Clear    <= 1'b0;
            oClear_Reject   <= 1'b0;
            oLeak_Sticky    <= '0;
            oRMC_PWR_Enable <= 1'b0;
        end else begin
            filtLargeQ    <= filtLarge;
            filtSmallQ    <= filtSmall;
            filtEnQ       <= filtEn;
            reqSync       <= {reqSync[0], iBMC_Clear_Req};
            oLatch_Clear  <= clearNow;
            oClear_Reject <= rejectNow;
            // A new fault in the grant cycle survives the clear
            oLeak_Sticky    <= (clearNow ? 3'b000 : oLeak_Sticky) | setEv;
            oRMC_PWR_Enable <= filtEn & ~oLeak_Sticky[RMC];

            case (state)
                IDLE: begin
                    if (reqSync[1]) begin
                        state   <= HOLD;
                        holdCnt <= '0;
                    end
                end
                HOLD: begin
                    if (!reqSync[1]) begin
                        state <= IDLE;
                    end else if (iTick_1ms) begin
                        if (holdInc >= {1'b0, HOLD_TH}) begin
                            state <= GRANT;
                        end else if (holdCnt != '1) begin
                            holdCnt <= holdInc[CNT_W-1:0];
                        end
                    end
                end
                GRANT: state <= WAIT_REL;
                WAIT_REL: begin
                    if (!reqSync[1]) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
